// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode constants and datapath select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EX   = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_FAULT     = 4'd15
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // Width of the watchdog stall timer; holds MEM_TIMEOUT up to 255.
    localparam int WD_W = 8;

    // States that wait on mem_ready and are therefore covered by the watchdog.
    function automatic logic is_mem_state(input mc_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_watchdog.sv
// Memory-access watchdog: down-counts consecutive stall cycles in a memory
// state and flags a timeout on the stall that would reach MEM_TIMEOUT.
module mc_watchdog
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [WD_W-1:0] LOAD = WD_W'(MEM_TIMEOUT);

    logic [WD_W-1:0] remaining;
    logic            stall;

    assign stall = active & ~mem_ready;

    // Reload whenever the access completes or we are outside a memory state,
    // so every fresh memory state starts with the full budget.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            remaining <= LOAD;
        else if (stall)
            remaining <= remaining - WD_W'(1);
        else
            remaining <= LOAD;
    end

    // Only a non-ready cycle can time out, so mem_ready on the limit cycle wins.
    assign timeout = stall & (remaining == WD_W'(1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the MIPS datapath: sequences FETCH..WRITEBACK,
// drives all datapath selects/enables, counts retired instructions and traps
// hung memory accesses into FAULT via mc_watchdog.
// Optional feature: define MC_JUMP_EN to support the j instruction (JUMP state);
// without it opcode 000010 is treated as illegal and leads to FAULT.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// FETCH     | read instruction at PC, latch IR and PC+4 when mem_ready
// DECODE    | compute branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | compute lw/sw effective address
// MEM_READ  | lw data read, wait for mem_ready
// MEM_WB    | write loaded data to rt
// MEM_WRITE | sw data write, wait for mem_ready
// EXECUTE   | R-type ALU operation (funct-controlled)
// R_WB      | write ALU result to rd
// BRANCH    | compare operands, branch selector loads PC from ALUOut
// JUMP      | load PC from jump target (MC_JUMP_EN only)
// ADDI_EX   | add sign-extended immediate
// ADDI_WB   | write ALU result to rt
// FAULT     | illegal opcode or memory timeout; held until reset
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic [1:0]       BranchOp,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ula_operation,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] instr_retired
);

    mc_state_e state_q;
    mc_state_e state_d;
    logic      timeout;

    // The branch decision itself (zero combined with BranchOp) lives in the
    // external branch selector; the flag is not needed to sequence states.
    logic unused_zero;
    assign unused_zero = zero;

    mc_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .active   (is_mem_state(state_q)),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    // Next-state logic; timeout can only fire on a non-ready cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (timeout)        state_d = ST_FAULT;
                else if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
                    OP_RTYPE:       state_d = ST_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_ADDI:        state_d = ST_ADDI_EX;
`ifdef MC_JUMP_EN
                    OP_J:           state_d = ST_JUMP;
`else
                    OP_J:           state_d = ST_FAULT;
`endif
                    default:        state_d = ST_FAULT;
                endcase
            end
            ST_MEM_ADDR:
                state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ: begin
                if (timeout)        state_d = ST_FAULT;
                else if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WRITE: begin
                if (timeout)        state_d = ST_FAULT;
                else if (mem_ready) state_d = ST_FETCH;
            end
            ST_MEM_WB:   state_d = ST_FETCH;
            ST_EXECUTE:  state_d = ST_R_WB;
            ST_R_WB:     state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
`ifdef MC_JUMP_EN
            ST_JUMP:     state_d = ST_FETCH;
`endif
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_ADDI_WB:  state_d = ST_FETCH;
            ST_FAULT:    state_d = ST_FAULT;
            default:     state_d = ST_FAULT;
        endcase
    end

    // Output decode from the current state; everything is forced low while
    // reset is held so an asynchronous reset never leaves a strobe asserted.
    always_comb begin
        PCWrite       = 1'b0;
        BranchOp      = BR_NONE;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ula_operation = ULA_ADD;
        PCSource      = PCSRC_ULA;
        fault         = 1'b0;
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    IRWrite  = mem_ready;
                    PCWrite  = mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcB = SRCB_SEXT_SH2;
                end
                ST_MEM_ADDR, ST_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SEXT;
                end
                ST_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_MEM_WB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_EXECUTE: begin
                    ALUSrcA       = 1'b1;
                    ula_operation = ULA_FUNCT;
                end
                ST_R_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ula_operation = ULA_SUB;
                    PCSource      = PCSRC_ALUOUT;
                    BranchOp      = (opcode == OP_BNE) ? BR_BNE : BR_BEQ;
                end
                // Unreachable unless jump support is built in.
                ST_JUMP: begin
                    PCSource = PCSRC_JUMP;
                    PCWrite  = 1'b1;
                end
                ST_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                ST_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    fault = 1'b0;
                end
            endcase
        end
    end

    // Retire count: any return to FETCH from another state completes an
    // instruction (FAULT never returns, FETCH stalls do not count).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            instr_retired <= '0;
        else if ((state_q != ST_FETCH) && (state_d == ST_FETCH))
            instr_retired <= instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table on a default
// instance plus hand sequences on a MEM_TIMEOUT=4 instance for the watchdog.
module tb_multicycle_control;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] JOP  = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] branch_op;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] ula_op;
        logic [1:0] pc_source;
        logic       fault;
    } ctl_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        ctl_t        ctl;
        logic [31:0] ret;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, fault;
    logic [1:0]  BranchOp, ALUSrcB, PCSource;
    logic [2:0]  ula_operation;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    logic        reset_wd = 1'b0;
    logic        rdy_wd = 1'b0;
    logic        wd_PCWrite, wd_IorD, wd_MemRead, wd_MemWrite, wd_IRWrite, wd_RegDst, wd_MemtoReg, wd_RegWrite, wd_ALUSrcA, wd_fault;
    logic [1:0]  wd_BranchOp, wd_ALUSrcB, wd_PCSource;
    logic [2:0]  wd_ula_operation;
    logic [3:0]  wd_state;
    logic [31:0] wd_instr_retired;

    int n_vec = 0;
    int n_err = 0;

    ctl_t w_zero, w_fetch_wait, w_fetch_rdy, w_decode, w_mem_addr, w_mem_read, w_mem_wb;
    ctl_t w_mem_write, w_exec, w_r_wb, w_beq, w_bne, w_addi_ex, w_addi_wb, w_jump, w_fault;
    ctl_t act;
    vec_t vq[$];

    always #5 clock = ~clock;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .BranchOp(BranchOp), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ula_operation(ula_operation), .PCSource(PCSource), .state(state), .fault(fault),
        .instr_retired(instr_retired)
    );

    multicycle_control #(.MEM_TIMEOUT(4)) dut_wd (
        .clock(clock), .reset(reset_wd), .opcode(opcode), .zero(zero), .mem_ready(rdy_wd),
        .PCWrite(wd_PCWrite), .BranchOp(wd_BranchOp), .IorD(wd_IorD), .MemRead(wd_MemRead),
        .MemWrite(wd_MemWrite), .IRWrite(wd_IRWrite), .RegDst(wd_RegDst),
        .MemtoReg(wd_MemtoReg), .RegWrite(wd_RegWrite), .ALUSrcA(wd_ALUSrcA),
        .ALUSrcB(wd_ALUSrcB), .ula_operation(wd_ula_operation), .PCSource(wd_PCSource),
        .state(wd_state), .fault(wd_fault), .instr_retired(wd_instr_retired)
    );

    task automatic add(input string n, input logic r, input logic [5:0] o, input logic z,
                       input logic rd, input logic [3:0] s, input ctl_t c, input logic [31:0] rt);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.z = z; v.rdy = rd; v.st = s; v.ctl = c; v.ret = rt;
        vq.push_back(v);
    endtask

    task automatic wd_cycle(input string n, input logic rst, input logic rdy,
                            input logic [3:0] exp_st, input logic exp_f);
        @(negedge clock);
        reset_wd = rst;
        rdy_wd   = rdy;
        @(posedge clock);
        #2;
        n_vec++;
        if (wd_state !== exp_st) begin
            n_err++;
            $display("FAIL %s state got %0d want %0d", n, wd_state, exp_st);
        end
        if (wd_fault !== exp_f) begin
            n_err++;
            $display("FAIL %s fault got %b want %b", n, wd_fault, exp_f);
        end
    endtask

    initial begin
        w_zero       = '0;
        w_fetch_wait = '0; w_fetch_wait.mem_read = 1'b1; w_fetch_wait.alu_src_b = 2'b01;
        w_fetch_rdy  = w_fetch_wait; w_fetch_rdy.ir_write = 1'b1; w_fetch_rdy.pc_write = 1'b1;
        w_decode     = '0; w_decode.alu_src_b = 2'b11;
        w_mem_addr   = '0; w_mem_addr.alu_src_a = 1'b1; w_mem_addr.alu_src_b = 2'b10;
        w_mem_read   = '0; w_mem_read.mem_read = 1'b1; w_mem_read.iord = 1'b1;
        w_mem_wb     = '0; w_mem_wb.mem_to_reg = 1'b1; w_mem_wb.reg_write = 1'b1;
        w_mem_write  = '0; w_mem_write.mem_write = 1'b1; w_mem_write.iord = 1'b1;
        w_exec       = '0; w_exec.alu_src_a = 1'b1; w_exec.ula_op = 3'b010;
        w_r_wb       = '0; w_r_wb.reg_dst = 1'b1; w_r_wb.reg_write = 1'b1;
        w_beq        = '0; w_beq.alu_src_a = 1'b1; w_beq.ula_op = 3'b001;
                           w_beq.pc_source = 2'b01; w_beq.branch_op = 2'b01;
        w_bne        = w_beq; w_bne.branch_op = 2'b10;
        w_addi_ex    = w_mem_addr;
        w_addi_wb    = '0; w_addi_wb.reg_write = 1'b1;
        w_jump       = '0; w_jump.pc_source = 2'b10; w_jump.pc_write = 1'b1;
        w_fault      = '0; w_fault.fault = 1'b1;

        //   name            rst op    z  rdy st  ctl          retired
        add("reset",          0, LW,   0, 1,  0, w_zero,       0);
        add("bad_fetch",      1, BAD,  0, 1,  0, w_fetch_rdy,  0);
        add("bad_decode",     1, BAD,  0, 1,  1, w_decode,     0);
        add("bad_fault",      1, BAD,  0, 1, 15, w_fault,      0);
        add("bad_sticky",     1, LW,   0, 1, 15, w_fault,      0);
        add("bad_reset",      0, LW,   0, 1,  0, w_zero,       0);
        add("lw_fetch",       1, LW,   0, 1,  0, w_fetch_rdy,  0);
        add("lw_decode",      1, LW,   0, 1,  1, w_decode,     0);
        add("lw_memaddr",     1, LW,   0, 1,  2, w_mem_addr,   0);
        add("lw_memread",     1, LW,   0, 1,  3, w_mem_read,   0);
        add("lw_memwb",       1, LW,   0, 1,  4, w_mem_wb,     0);
        add("beq_fetch",      1, BEQ,  1, 1,  0, w_fetch_rdy,  1);
        add("beq_decode",     1, BEQ,  1, 1,  1, w_decode,     1);
        add("beq_branch",     1, BEQ,  1, 1,  8, w_beq,        1);
        add("bne_fetch",      1, BNE,  0, 1,  0, w_fetch_rdy,  2);
        add("bne_decode",     1, BNE,  0, 1,  1, w_decode,     2);
        add("bne_branch",     1, BNE,  0, 1,  8, w_bne,        2);
        add("r_fetch",        1, RT,   0, 1,  0, w_fetch_rdy,  3);
        add("r_decode",       1, RT,   0, 1,  1, w_decode,     3);
        add("r_execute",      1, RT,   0, 1,  6, w_exec,       3);
        add("r_wb",           1, RT,   0, 1,  7, w_r_wb,       3);
        add("addi_fetch",     1, ADDI, 0, 1,  0, w_fetch_rdy,  4);
        add("addi_decode",    1, ADDI, 0, 1,  1, w_decode,     4);
        add("addi_ex",        1, ADDI, 0, 1, 10, w_addi_ex,    4);
        add("addi_wb",        1, ADDI, 0, 1, 11, w_addi_wb,    4);
        add("sw_fetch_wait1", 1, SW,   0, 0,  0, w_fetch_wait, 5);
        add("sw_fetch_wait2", 1, SW,   0, 0,  0, w_fetch_wait, 5);
        add("sw_fetch",       1, SW,   0, 1,  0, w_fetch_rdy,  5);
        add("sw_decode",      1, SW,   0, 1,  1, w_decode,     5);
        add("sw_memaddr",     1, SW,   0, 0,  2, w_mem_addr,   5);
        for (int k = 0; k < 5; k++)
            add("sw_write_stall", 1, SW, 0, 0, 5, w_mem_write, 5);
        add("sw_write_done",  1, SW,   0, 1,  5, w_mem_write,  5);
        add("j_fetch",        1, JOP,  0, 1,  0, w_fetch_rdy,  6);
        add("j_decode",       1, JOP,  0, 1,  1, w_decode,     6);
`ifdef MC_JUMP_EN
        add("j_jump",         1, JOP,  0, 1,  9, w_jump,       6);
        add("j_retired",      1, LW,   0, 1,  0, w_fetch_rdy,  7);
`else
        add("j_fault",        1, JOP,  0, 1, 15, w_fault,      6);
        add("j_fault_sticky", 1, LW,   0, 1, 15, w_fault,      6);
`endif
        add("pre_reset",      0, LW,   0, 1,  0, w_zero,       0);
        add("lw2_fetch",      1, LW,   0, 1,  0, w_fetch_rdy,  0);
        add("lw2_decode",     1, LW,   0, 1,  1, w_decode,     0);
        add("lw2_memaddr",    1, LW,   0, 1,  2, w_mem_addr,   0);
        add("lw2_memread",    1, LW,   0, 1,  3, w_mem_read,   0);
        add("lw2_memwb",      1, LW,   0, 1,  4, w_mem_wb,     0);
        add("lw3_fetch",      1, LW,   0, 1,  0, w_fetch_rdy,  1);
        add("lw3_decode",     1, LW,   0, 1,  1, w_decode,     1);
        add("lw3_memaddr",    1, LW,   0, 0,  2, w_mem_addr,   1);
        add("lw3_stall1",     1, LW,   0, 0,  3, w_mem_read,   1);
        add("lw3_stall2",     1, LW,   0, 0,  3, w_mem_read,   1);
        add("rst_mid_stall",  0, LW,   0, 0,  0, w_zero,       0);
        add("after_reset",    1, LW,   0, 1,  0, w_fetch_rdy,  0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            reset     = vq[i].rst;
            opcode    = vq[i].op;
            zero      = vq[i].z;
            mem_ready = vq[i].rdy;
            #2;
            n_vec++;
            act = {PCWrite, BranchOp, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ula_operation, PCSource, fault};
            if (state !== vq[i].st) begin
                n_err++;
                $display("FAIL %s[%0d] state got %0d want %0d", vq[i].name, i, state, vq[i].st);
            end
            if (act !== vq[i].ctl) begin
                n_err++;
                $display("FAIL %s[%0d] controls got %b want %b", vq[i].name, i, act, vq[i].ctl);
            end
            if (instr_retired !== vq[i].ret) begin
                n_err++;
                $display("FAIL %s[%0d] instr_retired got %0d want %0d", vq[i].name, i,
                         instr_retired, vq[i].ret);
            end
        end

        // Watchdog, MEM_TIMEOUT=4: ready on the limit cycle wins, then a
        // fresh MEM_READ gets the full budget and times out on its 4th stall.
        opcode = LW;
        wd_cycle("wd_reset",           0, 0,  0, 0);
        wd_cycle("wd_fetch_stall1",    1, 0,  0, 0);
        wd_cycle("wd_fetch_stall2",    1, 0,  0, 0);
        wd_cycle("wd_fetch_stall3",    1, 0,  0, 0);
        wd_cycle("wd_ready_at_limit",  1, 1,  1, 0);
        wd_cycle("wd_memaddr",         1, 1,  2, 0);
        wd_cycle("wd_memread",         1, 1,  3, 0);
        wd_cycle("wd_read_stall1",     1, 0,  3, 0);
        wd_cycle("wd_read_stall2",     1, 0,  3, 0);
        wd_cycle("wd_read_stall3",     1, 0,  3, 0);
        wd_cycle("wd_read_timeout",    1, 0, 15, 1);
        wd_cycle("wd_read_sticky",     1, 1, 15, 1);

        // FETCH stuck not-ready: FAULT after exactly 4 stall cycles, held until reset.
        wd_cycle("wd_reset2",          0, 0,  0, 0);
        wd_cycle("wd_fstuck1",         1, 0,  0, 0);
        wd_cycle("wd_fstuck2",         1, 0,  0, 0);
        wd_cycle("wd_fstuck3",         1, 0,  0, 0);
        wd_cycle("wd_fetch_timeout",   1, 0, 15, 1);
        wd_cycle("wd_fetch_sticky1",   1, 1, 15, 1);
        wd_cycle("wd_fetch_sticky2",   1, 1, 15, 1);
        if (wd_MemRead !== 1'b0 || wd_IRWrite !== 1'b0 || wd_PCWrite !== 1'b0) begin
            n_err++;
            $display("FAIL wd_fault_strobes got MemRead=%b IRWrite=%b PCWrite=%b want 0",
                     wd_MemRead, wd_IRWrite, wd_PCWrite);
        end
        wd_cycle("wd_reset3",          0, 1,  0, 0);
        n_vec++;
        if (wd_MemRead !== 1'b0 || wd_instr_retired !== 32'd0) begin
            n_err++;
            $display("FAIL wd_reset_outputs got MemRead=%b retired=%0d want 0 0",
                     wd_MemRead, wd_instr_retired);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
